// File: rtl/vga_tile_renderer_if.sv
// MMIO bus between the processor data-memory port and the tile renderer.
interface vga_tile_renderer_if;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/vga_tile_renderer.sv
// Tile-map pixel generator: looks up a 40x30 map of 16x16 tiles and produces
// registered VGA colour plus syncs delayed to match. Pixel work advances on pix_ce.
module vga_tile_renderer #(
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000,
  parameter int unsigned MAP_W      = 40,
  parameter int unsigned MAP_H      = 30,
  parameter int unsigned TILE_SHIFT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pix_ce,
  input  logic [9:0]                x,
  input  logic [8:0]                y,
  input  logic                      active,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      screen_end,
  vga_tile_renderer_if.slave        bus,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic [3:0]                VGA_R,
  output logic [3:0]                VGA_G,
  output logic [3:0]                VGA_B
);

  localparam int unsigned Depth = MAP_W * MAP_H;
  localparam int unsigned IdxW  = $clog2(Depth);
  localparam int unsigned PixW  = MAP_W << TILE_SHIFT;
  localparam int unsigned PixH  = MAP_H << TILE_SHIFT;

  localparam logic [11:0] OffCtrl  = 12'h800;
  localparam logic [11:0] OffBg    = 12'h801;
  localparam logic [11:0] OffFrame = 12'h802;

  // Register state
  logic            ctrl_en_q;
  logic [11:0]     bg_q;
  logic [31:0]     frame_q;
  logic [31:0]     rd_data_q, rd_data_d;

  // Pipeline state
  logic            valid_q;
  logic            active_q;
  logic            hsync_q, vsync_q;
  logic [12:0]     tile_q;
  logic [11:0]     rgb_q, rgb_d;
  logic            hsync_out_q, vsync_out_q;

  // Tile RAM, deliberately not reset
  logic [12:0]     tile_mem [Depth];

  logic            wr_hit, rd_hit;
  logic [11:0]     wr_off, rd_off;
  logic            tile_we;
  logic [31:0]     idx_raw;
  logic [IdxW-1:0] idx;

  logic            unused_wdata;
  assign unused_wdata = ^bus.wr_data[31:13];

  assign wr_hit  = bus.wr_addr[31:12] == MMIO_BASE[31:12];
  assign wr_off  = bus.wr_addr[11:0];
  assign rd_hit  = bus.rd_addr[31:12] == MMIO_BASE[31:12];
  assign rd_off  = bus.rd_addr[11:0];
  assign tile_we = bus.wr_en && wr_hit && (32'(wr_off) < Depth);

  // Tile index for the current pixel; out-of-range coordinates clamp to the last entry
  always_comb begin
    idx_raw = 32'(y >> TILE_SHIFT) * MAP_W + 32'(x >> TILE_SHIFT);
    if (32'(x) >= PixW || 32'(y) >= PixH || idx_raw >= Depth) begin
      idx = IdxW'(Depth - 1);
    end else begin
      idx = idx_raw[IdxW-1:0];
    end
  end

  // Tile RAM write port (MMIO side)
  always_ff @(posedge clock) begin
    if (tile_we) begin
      tile_mem[wr_off[IdxW-1:0]] <= bus.wr_data[12:0];
    end
  end

  // Tile RAM synchronous read port; a same-clock write returns the old entry
  always_ff @(posedge clock) begin
    if (pix_ce) begin
      tile_q <= tile_mem[idx];
    end
  end

  // Control registers and frame counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_en_q <= 1'b0;
      bg_q      <= 12'h000;
      frame_q   <= 32'h0;
    end else begin
      if (bus.wr_en && wr_hit && wr_off == OffCtrl) begin
        ctrl_en_q <= bus.wr_data[0];
      end
      if (bus.wr_en && wr_hit && wr_off == OffBg) begin
        bg_q <= bus.wr_data[11:0];
      end
      if (screen_end && pix_ce) begin
        frame_q <= frame_q + 32'd1;
      end
    end
  end

  // Read-back decode; tile entries are write-only and read as zero
  always_comb begin
    rd_data_d = 32'h0;
    if (rd_hit) begin
      unique case (rd_off)
        OffCtrl:  rd_data_d = {31'h0, ctrl_en_q};
        OffBg:    rd_data_d = {20'h0, bg_q};
        OffFrame: rd_data_d = frame_q;
        default:  rd_data_d = 32'h0;
      endcase
    end
  end

  // Registered read data, one clock after the address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_q <= 32'h0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  // Stage-2 colour selection: black when disabled, blanked or pipeline not primed
  always_comb begin
    rgb_d = 12'h000;
    if (ctrl_en_q && active_q && valid_q) begin
      rgb_d = tile_q[12] ? tile_q[11:0] : bg_q;
    end
  end

  // Stage-1 and stage-2 pipeline registers, advancing only on pixel ticks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      rgb_q       <= 12'h000;
      hsync_out_q <= 1'b1;
      vsync_out_q <= 1'b1;
    end else if (pix_ce) begin
      valid_q     <= 1'b1;
      active_q    <= active;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
      rgb_q       <= rgb_d;
      hsync_out_q <= hsync_q;
      vsync_out_q <= vsync_q;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign hsync_out   = hsync_out_q;
  assign vsync_out   = vsync_out_q;
  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];

endmodule
